// File: rtl/data_ram_ctrl.sv
// Data-side RAM responder: word-organised RAM with byte-lane writes, a
// one-cycle read-first registered read port, and a zero-fill sequence after reset.
module data_ram_ctrl #(
  parameter int          ADDR_WIDTH     = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_ram_en,
  input  logic [31:0] data_ram_addr,
  input  logic [3:0]  data_ram_w_en,
  input  logic [31:0] data_ram_w_data,
  output logic [31:0] data_ram_r_data,
  output logic        data_ram_ready,
  output logic        data_ram_addr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_idx_q;
  logic [ADDR_WIDTH-1:0]   clr_idx_d;
  logic [31:0]             r_data_q;
  logic                    ready_q;
  logic                    addr_err_q;

  logic [31:0]             mem [0:DEPTH-1];

  logic [31:0]             off;
  logic                    in_range;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    unused_off_bits;

  // Offset wraps, so addresses below BASE_ADDR land far out of range.
  assign off             = data_ram_addr - BASE_ADDR;
  assign in_range        = (off[31:ADDR_WIDTH+2] == '0);
  assign idx             = off[ADDR_WIDTH+1:2];
  assign unused_off_bits = ^off[1:0];
  assign clr_idx_d       = clr_idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        if (CLEAR_ON_RESET) begin
          mem[clr_idx_q] <= 32'h0;
        end
      end else if (data_ram_en && in_range) begin
        for (int i = 0; i < 4; i++) begin
          if (data_ram_w_en[i]) begin
            mem[idx][8*i +: 8] <= data_ram_w_data[8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= '0;
      r_data_q   <= 32'h0;
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          r_data_q   <= 32'h0;
          addr_err_q <= 1'b0;
          clr_idx_q  <= clr_idx_d;
          if (!CLEAR_ON_RESET || (&clr_idx_q)) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          if (data_ram_en) begin
            if (in_range) begin
              r_data_q   <= mem[idx];
              addr_err_q <= 1'b0;
            end else begin
              r_data_q   <= 32'h0;
              addr_err_q <= 1'b1;
            end
          end else begin
            addr_err_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_ram_r_data   = r_data_q;
  assign data_ram_ready    = ready_q;
  assign data_ram_addr_err = addr_err_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl: init timing, byte lanes, read-first,
// range errors, and reset during clear / ready.
module tb_data_ram_ctrl;

  localparam int          AW   = 4;
  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] addr;
  logic [3:0]  w_en;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        ready;
  logic        addr_err;

  logic        nc_en;
  logic [31:0] nc_addr;
  logic [3:0]  nc_w_en;
  logic [31:0] nc_w_data;
  logic [31:0] nc_r_data;
  logic        nc_ready;
  logic        nc_addr_err;

  int total = 0;
  int bad   = 0;

  data_ram_ctrl #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clk               (clk),
    .reset             (reset),
    .data_ram_en       (en),
    .data_ram_addr     (addr),
    .data_ram_w_en     (w_en),
    .data_ram_w_data   (w_data),
    .data_ram_r_data   (r_data),
    .data_ram_ready    (ready),
    .data_ram_addr_err (addr_err)
  );

  data_ram_ctrl #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b0)) u_dut_nc (
    .clk               (clk),
    .reset             (reset),
    .data_ram_en       (nc_en),
    .data_ram_addr     (nc_addr),
    .data_ram_w_en     (nc_w_en),
    .data_ram_w_data   (nc_w_data),
    .data_ram_r_data   (nc_r_data),
    .data_ram_ready    (nc_ready),
    .data_ram_addr_err (nc_addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic [3:0]  w_en;
    logic [31:0] w_data;
    logic [31:0] exp_r;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic req(input logic e, input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    en     = e;
    addr   = a;
    w_en   = we;
    w_data = wd;
  endtask

  task automatic read_word(input int w, input logic [31:0] exp, input string name);
    req(1'b1, BASE + 32'(w * 4), 4'b0000, 32'h0);
    tick();
    chk(name, r_data, exp);
    chk({name, "_err"}, {31'h0, addr_err}, 32'h0);
  endtask

  initial begin
    logic [31:0] exp_w;

    vecs[0]  = '{1'b1, BASE + 32'h10, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, BASE + 32'h10, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, BASE + 32'h12, 4'b0100, 32'h00AA_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, BASE + 32'h10, 4'b0000, 32'h0000_0000, 32'hDEAA_BEEF, 1'b0};
    vecs[4]  = '{1'b1, BASE + 32'h13, 4'b1000, 32'h5500_0000, 32'hDEAA_BEEF, 1'b0};
    vecs[5]  = '{1'b1, BASE + 32'h10, 4'b0000, 32'h0000_0000, 32'h55AA_BEEF, 1'b0};
    vecs[6]  = '{1'b0, BASE + 32'h20, 4'b1111, 32'hFFFF_FFFF, 32'h55AA_BEEF, 1'b0};
    vecs[7]  = '{1'b1, BASE + 32'h20, 4'b1111, 32'h1111_1111, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b1, BASE + 32'h20, 4'b1111, 32'h2222_2222, 32'h1111_1111, 1'b0};
    vecs[9]  = '{1'b1, BASE + 32'h20, 4'b0000, 32'h0000_0000, 32'h2222_2222, 1'b0};
    vecs[10] = '{1'b1, BASE + 32'h40, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, BASE + 32'h10, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b1, BASE + 32'h10, 4'b0000, 32'h0000_0000, 32'h55AA_BEEF, 1'b0};
    vecs[13] = '{1'b1, 32'h1BFF_FFFC,  4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[14] = '{1'b1, BASE + 32'h3C, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[15] = '{1'b1, BASE + 32'h40, 4'b1111, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1};
    vecs[16] = '{1'b1, 32'h1BFF_FFFC,  4'b1111, 32'h5A5A_5A5A, 32'h0000_0000, 1'b1};
    vecs[17] = '{1'b1, BASE + 32'h21, 4'b0001, 32'h0000_00CC, 32'h2222_2222, 1'b0};
    vecs[18] = '{1'b1, BASE + 32'h20, 4'b0000, 32'h0000_0000, 32'h2222_22CC, 1'b0};

    nc_en = 1'b0; nc_addr = 32'h0; nc_w_en = 4'b0; nc_w_data = 32'h0;
    req(1'b0, 32'h0, 4'b0000, 32'h0);

    // Initial reset and zero-fill
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_r_data", r_data, 32'h0);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
    chk("rst_nc_ready", {31'h0, nc_ready}, 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 10) req(1'b1, BASE, 4'b1111, 32'hFFFF_FFFF);
      else if (k == 11) req(1'b1, BASE + 32'h40, 4'b0000, 32'h0);
      else req(1'b0, 32'h0, 4'b0000, 32'h0);
      tick();
      chk($sformatf("init_ready_%0d", k), {31'h0, ready}, {31'h0, (k == 16)});
      if (k < 16) begin
        chk($sformatf("init_r_data_%0d", k), r_data, 32'h0);
        chk($sformatf("init_err_%0d", k), {31'h0, addr_err}, 32'h0);
      end
      if (k == 1) chk("nc_ready_first_edge", {31'h0, nc_ready}, 32'h1);
    end
    for (int w = 0; w < 16; w++) read_word(w, 32'h0, $sformatf("zero_w%0d", w));

    // Table-driven main function vectors
    for (int i = 0; i < NVEC; i++) begin
      req(vecs[i].en, vecs[i].addr, vecs[i].w_en, vecs[i].w_data);
      tick();
      chk($sformatf("vec%0d_r_data", i), r_data, vecs[i].exp_r);
      chk($sformatf("vec%0d_err", i), {31'h0, addr_err}, {31'h0, vecs[i].exp_err});
    end
    req(1'b0, 32'h0, 4'b0000, 32'h0);
    tick();
    chk("err_one_cycle", {31'h0, addr_err}, 32'h0);

    // Out-of-range writes must not alias onto any word
    for (int w = 0; w < 16; w++) begin
      exp_w = (w == 4) ? 32'h55AA_BEEF : (w == 8) ? 32'h2222_22CC : 32'h0;
      read_word(w, exp_w, $sformatf("scan_w%0d", w));
    end

    // Reset in READY with a request in the same cycle
    reset = 1'b1;
    req(1'b1, BASE + 32'h10, 4'b1111, 32'hFFFF_FFFF);
    tick();
    chk("rdy_rst_ready", {31'h0, ready}, 32'h0);
    chk("rdy_rst_r_data", r_data, 32'h0);
    chk("rdy_rst_err", {31'h0, addr_err}, 32'h0);
    reset = 1'b0;
    req(1'b0, 32'h0, 4'b0000, 32'h0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("pre_ready_%0d", k), {31'h0, ready}, 32'h0);
    end

    // Reset at clear index 7 restarts the fill
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) req(1'b1, BASE + 32'h10, 4'b0000, 32'h0);
      else if (k == 6) req(1'b1, BASE + 32'h40, 4'b0000, 32'h0);
      else req(1'b0, 32'h0, 4'b0000, 32'h0);
      tick();
      chk($sformatf("re_ready_%0d", k), {31'h0, ready}, {31'h0, (k == 16)});
      if (k < 16) begin
        chk($sformatf("re_r_data_%0d", k), r_data, 32'h0);
        chk($sformatf("re_err_%0d", k), {31'h0, addr_err}, 32'h0);
      end
    end
    for (int w = 0; w < 16; w++) read_word(w, 32'h0, $sformatf("rezero_w%0d", w));
    req(1'b0, 32'h0, 4'b0000, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
